// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: dmem command/size codes, entry states and a saturating-increment helper
package dmem_port_arbiter_pkg;
  localparam logic [4:0] M_XRD = 5'd0;
  localparam logic [4:0] M_XWR = 5'd1;
  localparam logic [2:0] MT_B  = 3'd0;
  localparam logic [2:0] MT_H  = 3'd1;
  localparam logic [2:0] MT_W  = 3'd2;
  localparam logic [2:0] MT_D  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd4;
  localparam logic [2:0] MT_HU = 3'd5;
  localparam logic [2:0] MT_WU = 3'd6;
  typedef enum logic [2:0] {IDLE, PEND, S1, S2, WAIT} entry_state_e;
  function automatic logic [31:0] sat_inc(logic [31:0] v, logic en);
    return v + 32'(en && v != '1);
  endfunction
endpackage

// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter: round-robin pick from ptr, with the lowest-index priority request overriding it
module dmem_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] pri,
  input  logic [ID_W-1:0] ptr,
  output logic            gnt_valid,
  output logic            gnt_pri,
  output logic [ID_W-1:0] gnt_id
);
  logic found;
  int   idx;
  // first request at or after ptr, then any priority request replaces it (descending so lowest wins)
  always_comb begin
    gnt_valid = |req;
    gnt_pri = |pri;
    gnt_id = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        gnt_id = ID_W'(idx);
        found = 1'b1;
      end
    end
    for (int k = NREQ - 1; k >= 0; k--) if (pri[k]) gnt_id = ID_W'(k);
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one HellaCache dmem port among NREQ requesters (optional counters: DMEM_PORT_ARBITER_STATS_EN)
module dmem_port_arbiter import dmem_port_arbiter_pkg::*; #(
  parameter int NREQ   = 4,
  parameter int ID_W   = 2,
  parameter int ADDR_W = 40,
  parameter int DATA_W = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          rq_valid,
  output logic [NREQ-1:0]          rq_ready,
  input  logic [NREQ*ADDR_W-1:0]   rq_addr,
  input  logic [NREQ*5-1:0]        rq_cmd,
  input  logic [NREQ*3-1:0]        rq_typ,
  input  logic [NREQ*DATA_W-1:0]   rq_data,
  input  logic [NREQ*8-1:0]        rq_mask,
  output logic [NREQ-1:0]          cpl_valid,
  output logic [NREQ-1:0]          cpl_err,
  output logic [DATA_W-1:0]        cpl_data,
  input  logic                     dmem_req_ready,
  output logic                     dmem_req_valid,
  output logic [ADDR_W-1:0]        dmem_req_addr,
  output logic [6:0]               dmem_req_tag,
  output logic [4:0]               dmem_req_cmd,
  output logic [2:0]               dmem_req_typ,
  output logic                     dmem_req_phys,
  output logic                     dmem_s1_kill,
  output logic [DATA_W-1:0]        dmem_s1_data,
  output logic [7:0]               dmem_s1_mask,
  input  logic                     dmem_s2_nack,
  input  logic                     dmem_s2_xcpt,
  input  logic                     dmem_resp_valid,
  input  logic [6:0]               dmem_resp_tag,
  input  logic [DATA_W-1:0]        dmem_resp_data
`ifdef DMEM_PORT_ARBITER_STATS_EN
  ,
  output logic [31:0]              stat_fires,
  output logic [31:0]              stat_nacks,
  output logic [31:0]              stat_xcpts,
  output logic [31:0]              stat_stray_resp
`endif
);
  entry_state_e                  st_q [NREQ];
  entry_state_e                  st_d [NREQ];
  logic [NREQ-1:0]               rep_q, rep_d;
  logic [NREQ-1:0][ADDR_W-1:0]   addr_q, addr_d;
  logic [NREQ-1:0][4:0]          cmd_q, cmd_d;
  logic [NREQ-1:0][2:0]          typ_q, typ_d;
  logic [NREQ-1:0][DATA_W-1:0]   data_q, data_d;
  logic [NREQ-1:0][7:0]          mask_q, mask_d;
  logic [ID_W-1:0]               rr_q, rr_d, s1_id_q, s1_id_d, s2_id_q, s2_id_d, gnt_id;
  logic                          s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [NREQ-1:0]               cpl_valid_q, cpl_valid_d, cpl_err_q, cpl_err_d;
  logic [DATA_W-1:0]             cpl_data_q, cpl_data_d;
  logic [NREQ-1:0]               pend, resp_hit;
  logic                          gnt_valid, gnt_pri, fire, s2_nack, s2_xcpt, unused_tag;

  assign fire = gnt_valid & dmem_req_ready;
  assign s2_nack = s2_v_q & dmem_s2_nack;
  assign s2_xcpt = s2_v_q & dmem_s2_xcpt & ~dmem_s2_nack;
  assign unused_tag = ^dmem_resp_tag[6:ID_W];

  dmem_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req       (pend),
    .pri       (pend & rep_q),
    .ptr       (rr_q),
    .gnt_valid (gnt_valid),
    .gnt_pri   (gnt_pri),
    .gnt_id    (gnt_id)
  );

  // per-entry status: free, arbitrating, or matched by the returning response tag
  always_comb begin
    rq_ready = '0;
    pend = '0;
    resp_hit = '0;
    for (int i = 0; i < NREQ; i++) begin
      rq_ready[i] = st_q[i] == IDLE;
      pend[i] = st_q[i] == PEND;
      resp_hit[i] = dmem_resp_valid && st_q[i] == WAIT && dmem_resp_tag[ID_W-1:0] == ID_W'(i);
    end
  end

  // control state, pipeline trackers and registered completions
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) st_q[i] <= IDLE;
      rep_q <= '0;
      rr_q <= '0;
      s1_v_q <= 1'b0;
      s1_id_q <= '0;
      s2_v_q <= 1'b0;
      s2_id_q <= '0;
      cpl_valid_q <= '0;
      cpl_err_q <= '0;
      cpl_data_q <= '0;
    end else begin
      st_q <= st_d;
      rep_q <= rep_d;
      rr_q <= rr_d;
      s1_v_q <= s1_v_d;
      s1_id_q <= s1_id_d;
      s2_v_q <= s2_v_d;
      s2_id_q <= s2_id_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_err_q <= cpl_err_d;
      cpl_data_q <= cpl_data_d;
    end
  end

  // captured request payload needs no reset: it is only observed outside IDLE
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    cmd_q <= cmd_d;
    typ_q <= typ_d;
    data_q <= data_d;
    mask_q <= mask_d;
  end

  // entry FSMs, rr pointer (advances only on non-replay fires) and the s1/s2 id pipeline
  always_comb begin
    st_d = st_q;
    rep_d = rep_q;
    addr_d = addr_q;
    cmd_d = cmd_q;
    typ_d = typ_q;
    data_d = data_q;
    mask_d = mask_q;
    for (int i = 0; i < NREQ; i++) begin
      case (st_q[i])
        IDLE: if (rq_valid[i]) begin
          st_d[i] = PEND;
          rep_d[i] = 1'b0;
          addr_d[i] = rq_addr[i*ADDR_W +: ADDR_W];
          cmd_d[i] = rq_cmd[i*5 +: 5];
          typ_d[i] = rq_typ[i*3 +: 3];
          data_d[i] = rq_data[i*DATA_W +: DATA_W];
          mask_d[i] = rq_mask[i*8 +: 8];
        end
        PEND: if (fire && gnt_id == ID_W'(i)) begin
          st_d[i] = S1;
          rep_d[i] = 1'b0;
        end
        S1: st_d[i] = S2;
        S2: begin
          st_d[i] = s2_nack ? PEND : (s2_xcpt || cmd_q[i] == M_XWR) ? IDLE : WAIT;
          rep_d[i] = s2_nack;
        end
        WAIT: if (resp_hit[i]) st_d[i] = IDLE;
        default: st_d[i] = IDLE;
      endcase
    end
    rr_d = (fire && !gnt_pri) ? ((gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1)) : rr_q;
    s1_v_d = fire;
    s1_id_d = gnt_id;
    s2_v_d = s1_v_q;
    s2_id_d = s1_id_q;
  end

  // completions: s2 store/exception outcome and load responses, both may land in one cycle
  always_comb begin
    cpl_valid_d = '0;
    cpl_err_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      cpl_valid_d[i] = (s2_v_q && s2_id_q == ID_W'(i) && !s2_nack && (s2_xcpt || cmd_q[i] == M_XWR)) || resp_hit[i];
      cpl_err_d[i] = s2_id_q == ID_W'(i) && s2_xcpt;
    end
    cpl_data_d = |resp_hit ? dmem_resp_data : '0;
  end

  // dmem request side is steered from the granted entry; s1 data from the entry fired last cycle
  always_comb begin
    dmem_req_valid = gnt_valid;
    dmem_req_addr = gnt_valid ? addr_q[gnt_id] : '0;
    dmem_req_tag = gnt_valid ? 7'(gnt_id) : '0;
    dmem_req_cmd = gnt_valid ? cmd_q[gnt_id] : '0;
    dmem_req_typ = gnt_valid ? typ_q[gnt_id] : '0;
    dmem_req_phys = 1'b0;
    dmem_s1_kill = 1'b0;
    dmem_s1_data = s1_v_q ? data_q[s1_id_q] : '0;
    dmem_s1_mask = s1_v_q ? mask_q[s1_id_q] : '0;
    cpl_valid = cpl_valid_q;
    cpl_err = cpl_err_q;
    cpl_data = cpl_data_q;
  end

`ifdef DMEM_PORT_ARBITER_STATS_EN
  logic [31:0] stat_fires_q, stat_fires_d, stat_nacks_q, stat_nacks_d;
  logic [31:0] stat_xcpts_q, stat_xcpts_d, stat_stray_resp_q, stat_stray_resp_d;

  // saturating event counters
  always_comb begin
    stat_fires_d = sat_inc(stat_fires_q, fire);
    stat_nacks_d = sat_inc(stat_nacks_q, s2_nack);
    stat_xcpts_d = sat_inc(stat_xcpts_q, s2_xcpt);
    stat_stray_resp_d = sat_inc(stat_stray_resp_q, dmem_resp_valid && !(|resp_hit));
    stat_fires = stat_fires_q;
    stat_nacks = stat_nacks_q;
    stat_xcpts = stat_xcpts_q;
    stat_stray_resp = stat_stray_resp_q;
  end

  // counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_fires_q <= '0;
      stat_nacks_q <= '0;
      stat_xcpts_q <= '0;
      stat_stray_resp_q <= '0;
    end else begin
      stat_fires_q <= stat_fires_d;
      stat_nacks_q <= stat_nacks_d;
      stat_xcpts_q <= stat_xcpts_d;
      stat_stray_resp_q <= stat_stray_resp_d;
    end
  end
`endif
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single core-side HellaCache dmem port between NREQ independent traffic requesters in the subsystem testbench/SoC.
- Per-requester request capture, round-robin grant, s1 data steering and s2 nack replay.
- Routes responses back by tag and signals completion or error to each requester.
- At most one outstanding access per requester.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ID_W, 2, requester-id bits, equal to clog2(NREQ)
- ADDR_W, 40, dmem address width
- DATA_W, 64, dmem data width

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- rq_valid  in  NREQ  request valid per requester
- rq_ready  out  NREQ  entry free; request accepted when valid&ready
- rq_addr  in  NREQ*ADDR_W  address, requester i in slice i
- rq_cmd  in  NREQ*5  M_XRD=0 or M_XWR=1
- rq_typ  in  NREQ*3  MT_* size code
- rq_data  in  NREQ*DATA_W  store data
- rq_mask  in  NREQ*8  store byte mask
- cpl_valid  out  NREQ  one-cycle completion pulse
- cpl_err  out  NREQ  completion was an s2 exception
- cpl_data  out  DATA_W  load data; valid with a load completion
- dmem_req_ready  in  1
- dmem_req_valid  out  1
- dmem_req_addr  out  ADDR_W
- dmem_req_tag  out  7  {zeros, id}
- dmem_req_cmd  out  5
- dmem_req_typ  out  3
- dmem_req_phys  out  1  tied 0
- dmem_s1_kill  out  1  tied 0
- dmem_s1_data  out  DATA_W
- dmem_s1_mask  out  8
- dmem_s2_nack  in  1
- dmem_s2_xcpt  in  1  OR of ma/pf/ae ld/st
- dmem_resp_valid  in  1
- dmem_resp_tag  in  7
- dmem_resp_data  in  DATA_W

Behaviour:
- Reset: all entries IDLE, rr pointer 0, s1/s2 trackers empty. All outputs 0 except rq_ready, which is all-ones.
- Entry FSM per requester:
  - IDLE: rq_ready=1. On rq_valid, capture addr/cmd/typ/data/mask and go to PEND.
  - PEND: eligible for grant. On grant with dmem_req_ready, go to S1.
  - S1 -> S2 unconditionally on the next cycle.
  - S2, on dmem_s2_nack: go to PEND and set replay flag.
  - S2, else on dmem_s2_xcpt: cpl_valid=1, cpl_err=1, go to IDLE.
  - S2, else on store: cpl_valid=1, go to IDLE.
  - S2, else on load: go to WAIT.
  - WAIT: on dmem_resp_valid with tag[ID_W-1:0]==i, cpl_valid=1, cpl_data=resp_data, go to IDLE.
- Grant:
  - Any PEND entry with replay set wins first (lowest index).
  - Otherwise round-robin starting at rr pointer.
  - rr pointer advances to grantee+1 (mod NREQ) only on a non-replay fire.
  - dmem_req_valid = any PEND. Address/cmd/typ/tag are combinational from the selected entry.
- s1_data/s1_mask are driven from the entry in S1, one cycle after fire; 0 when none.
- s2 decisions apply to the entry whose id was fired two cycles earlier (s1_id/s2_id pipeline).
- Back-to-back fires are allowed every cycle. Throughput is 1 request/cycle across requesters.
- Latency:
  - rq_valid to dmem_req_valid is 1 cycle.
  - Store completion is 3 cycles after fire.
- Simultaneous events:
  - A store S2 completion and a load resp completion for different requesters in the same cycle both pulse cpl_valid. Only the load drives cpl_data.
  - A resp whose id entry is not in WAIT is dropped.
  - A nack and a new grant in the same cycle are legal, since they are different requesters.
- Reset mid-operation: in-flight responses arriving after reset are dropped (no entry in WAIT).

Optional Feature:
- DMEM_PORT_ARBITER_STATS_EN adds 32-bit saturating outputs stat_fires, stat_nacks, stat_xcpts and stat_stray_resp, all cleared on reset.
- Without the macro these ports and counters do not exist.

Decomposition:
- Package dmem_port_arbiter_pkg holds M_XRD/M_XWR, the MT_* codes and the entry_state_e enum (IDLE, PEND, S1, S2, WAIT).
- One sub-module, dmem_rr_arbiter: NREQ-wide round-robin with a priority-override input.

Test Plan:
- Single load from requester 0 to addr 0x6000_0000, resp tag 0 data 0x5 -> cpl_valid[0] with cpl_data=0x5; dmem tag=0; rq_ready[0] low until completion.
- All 4 requesters valid together, ready always 1 -> fires in order 0,1,2,3 on consecutive cycles; s1_data follows each fire by 1 cycle.
- Store from requester 2 with dmem_s2_nack on first attempt -> re-fired before pending requester 1 with identical addr/data; cpl_valid[2] 3 cycles after second fire.
- Load from requester 1 with s2_xcpt -> cpl_valid[1]=1 and cpl_err[1]=1; no WAIT; a later resp with tag 1 is ignored.
- Store completion for requester 3 coincides with load resp for requester 0 -> both cpl_valid bits set in the same cycle; cpl_data carries the load data.
- Reset asserted while requester 0 is in WAIT -> rq_ready all-ones the next cycle; the late resp produces no cpl_valid.
